mult_controller: RTL and testbench

Sequencing FSM for the normalising approximate multiplier datapath. It accepts a start request, loads the A/B shift registers, and left-normalises each operand until its MSB is set while counting shifts in the 5-bit counter. It then captures the 8×8 product of the operand top bytes and right-shifts the result register once per counted shift. It drives every datapath control strobe, consumes the datapath status flags, and presents a ready/start/done handshake to the surrounding system.

---
 rtl/mult_pkg.sv | 27 ++
 rtl/mult_controller_guard.sv | 28 ++
 rtl/mult_controller.sv | 140 ++++++++++++++
 tb/tb_mult_controller.sv | 207 ++++++++++++++++++++
 4 files changed

// File: rtl/mult_pkg.sv
// Shared types and constants for the normalising approximate multiplier controller.
package mult_pkg;

    localparam int OP_WIDTH_DEF = 16;
    localparam int CNT_W        = 5;

    typedef enum logic [2:0] {
        ST_IDLE      = 3'd0,
        ST_LOAD      = 3'd1,
        ST_SHIFT_A   = 3'd2,
        ST_SHIFT_B   = 3'd3,
        ST_MULT      = 3'd4,
        ST_SHIFT_OUT = 3'd5,
        ST_DONE      = 3'd6
    } mult_state_t;

    // Guard counter must hold OP_WIDTH-1, the last legal shift index.
    function automatic int guard_width(input int op_width);
        return (op_width > 2) ? $clog2(op_width) : 1;
    endfunction

    // Worst-case total counted shifts; must stay below 2**CNT_W.
    function automatic int max_shift(input int op_width);
        return 2 * (op_width - 1);
    endfunction

endpackage

// File: rtl/mult_controller_guard.sv
// Clearable, enabled up-counter with a terminal-value flag; bounds operand normalisation.
module shift_guard_counter #(
    parameter int               WIDTH    = 4,
    parameter logic [WIDTH-1:0] TERMINAL = '1
) (
    input  logic clk,
    input  logic rst,
    input  logic clr,
    input  logic en,
    output logic at_terminal
);

    logic [WIDTH-1:0] count;

    // NOTE: state is updated with non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            count <= '0;
        end else if (clr) begin
            count <= '0;
        end else if (en) begin
            count <= count + 1'b1;
        end
    end

    assign at_terminal = (count == TERMINAL);

endmodule

// File: rtl/mult_controller.sv
// Sequencing FSM: load, normalise A then B, multiply top bytes, denormalise the result.
module mult_controller
    import mult_pkg::*;
#(
    parameter int OP_WIDTH = OP_WIDTH_DEF
) (
    input  logic clk,
    input  logic rst,
    input  logic start,
    input  logic DoneA,
    input  logic DoneB,
    input  logic down_done,
    output logic loadA,
    output logic loadB,
    output logic ShlA,
    output logic ShlB,
    output logic rst5,
    output logic cntU,
    output logic cntD,
    output logic loadOut,
    output logic ShrOut,
    output logic ready,
    output logic done,
    output logic zero
);

    localparam int GUARD_W = guard_width(OP_WIDTH);

    mult_state_t state, state_next;
    logic        zero_q;
    logic        zero_set;
    logic        guard_clr;
    logic        guard_en;
    logic        guard_full;

    shift_guard_counter #(
        .WIDTH    (GUARD_W),
        .TERMINAL (GUARD_W'(OP_WIDTH - 1))
    ) u_guard (
        .clk         (clk),
        .rst         (rst),
        .clr         (guard_clr),
        .en          (guard_en),
        .at_terminal (guard_full)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state  <= ST_IDLE;
            zero_q <= 1'b0;
        end else begin
            state <= state_next;
            if (state == ST_LOAD) begin
                zero_q <= 1'b0;
            end else if (zero_set) begin
                zero_q <= 1'b1;
            end
        end
    end

    always_comb begin
        // NOTE: every output gets a default first so no path through the case infers a latch.
        state_next = state;
        loadA      = 1'b0;
        loadB      = 1'b0;
        ShlA       = 1'b0;
        ShlB       = 1'b0;
        rst5       = 1'b0;
        cntU       = 1'b0;
        cntD       = 1'b0;
        loadOut    = 1'b0;
        ShrOut     = 1'b0;
        ready      = 1'b0;
        done       = 1'b0;
        zero       = 1'b0;
        zero_set   = 1'b0;
        guard_clr  = 1'b0;
        guard_en   = 1'b0;

        unique case (state)
            ST_IDLE: begin
                ready = 1'b1;
                if (start) state_next = ST_LOAD;
            end
            ST_LOAD: begin
                loadA      = 1'b1;
                loadB      = 1'b1;
                rst5       = 1'b1;
                guard_clr  = 1'b1;
                state_next = ST_SHIFT_A;
            end
            // MSB test wins over the guard so an operand needing the full shift count still completes.
            ST_SHIFT_A: begin
                if (DoneA) begin
                    guard_clr  = 1'b1;
                    state_next = ST_SHIFT_B;
                end else if (guard_full) begin
                    zero_set   = 1'b1;
                    state_next = ST_DONE;
                end else begin
                    ShlA     = 1'b1;
                    cntU     = 1'b1;
                    guard_en = 1'b1;
                end
            end
            ST_SHIFT_B: begin
                if (DoneB) begin
                    guard_clr  = 1'b1;
                    state_next = ST_MULT;
                end else if (guard_full) begin
                    zero_set   = 1'b1;
                    state_next = ST_DONE;
                end else begin
                    ShlB     = 1'b1;
                    cntU     = 1'b1;
                    guard_en = 1'b1;
                end
            end
            ST_MULT: begin
                loadOut    = 1'b1;
                state_next = ST_SHIFT_OUT;
            end
            ST_SHIFT_OUT: begin
                if (down_done) begin
                    state_next = ST_DONE;
                end else begin
                    ShrOut = 1'b1;
                    cntD   = 1'b1;
                end
            end
            ST_DONE: begin
                done       = 1'b1;
                zero       = zero_q;
                state_next = ST_IDLE;
            end
            default: state_next = ST_IDLE;
        endcase
    end

endmodule

// File: tb/tb_mult_controller.sv
// Self-checking bench: behavioural datapath around the controller, table and random operands.
module tb_mult_controller;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic start = 1'b0;
    logic DoneA, DoneB, down_done;
    logic loadA, loadB, ShlA, ShlB, rst5, cntU, cntD, loadOut, ShrOut;
    logic ready, done, zero;

    mult_controller #(.OP_WIDTH(16)) dut (
        .clk(clk), .rst(rst), .start(start),
        .DoneA(DoneA), .DoneB(DoneB), .down_done(down_done),
        .loadA(loadA), .loadB(loadB), .ShlA(ShlA), .ShlB(ShlB),
        .rst5(rst5), .cntU(cntU), .cntD(cntD),
        .loadOut(loadOut), .ShrOut(ShrOut),
        .ready(ready), .done(done), .zero(zero)
    );

    always #5 clk = ~clk;

    // Behavioural datapath: operand shift registers and the 5-bit shift counter.
    logic [15:0] a_in = '0, b_in = '0;
    logic [15:0] a_reg = '0, b_reg = '0;
    logic [4:0]  cnt = '0;

    always @(posedge clk) begin
        if (loadA) a_reg <= a_in; else if (ShlA) a_reg <= a_reg << 1;
        if (loadB) b_reg <= b_in; else if (ShlB) b_reg <= b_reg << 1;
        if (rst5) cnt <= '0; else if (cntU) cnt <= cnt + 5'd1; else if (cntD) cnt <= cnt - 5'd1;
    end

    assign DoneA     = a_reg[15];
    assign DoneB     = b_reg[15];
    assign down_done = (cnt == 5'd0);

    typedef struct {
        logic [15:0] a;
        logic [15:0] b;
        int done_cyc;
        int shla;
        int shlb;
        int shr;
        int zero;
        int loadout;
    } vec_t;

    int n_cmp  = 0;
    int n_fail = 0;

    task automatic check(input string name, input int act, input int exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    function automatic int clz16(input logic [15:0] x);
        for (int i = 15; i >= 0; i--) if (x[i]) return 15 - i;
        return 16;
    endfunction

    // Reference timing derived from leading-zero counts of the operands.
    function automatic vec_t expect_vec(input logic [15:0] a, input logic [15:0] b);
        vec_t v;
        int ka, kb;
        ka = clz16(a);
        kb = clz16(b);
        v.a = a;
        v.b = b;
        if (a == 0) begin
            v.done_cyc = 2 + 16; v.shla = 15; v.shlb = 0; v.shr = 0; v.zero = 1; v.loadout = 0;
        end else if (b == 0) begin
            v.done_cyc = 1 + (ka + 1) + 16 + 1; v.shla = ka; v.shlb = 15; v.shr = 0;
            v.zero = 1; v.loadout = 0;
        end else begin
            v.done_cyc = 2 * (ka + kb) + 6; v.shla = ka; v.shlb = kb; v.shr = ka + kb;
            v.zero = 0; v.loadout = 1;
        end
        return v;
    endfunction

    function automatic int strobes();
        return int'({loadA, loadB, ShlA, ShlB, rst5, cntU, cntD, loadOut, ShrOut, done, zero});
    endfunction

    task automatic wait_ready(input string tag);
        int n = 0;
        while (!ready && n < 100) begin
            @(negedge clk);
            n++;
        end
        check({tag, "_ready_timeout"}, int'(ready), 1);
    endtask

    // Launch one operation, count strobes per cycle until done, compare with expectations.
    task automatic run_op(input vec_t v, input bit pulse_mid, input bit hold, input string tag);
        int cyc = 0, c_shla = 0, c_shlb = 0, c_shr = 0, c_cu = 0, c_cd = 0, c_lo = 0;
        int done_cyc = -1, zero_at = -1;
        wait_ready(tag);
        check({tag, "_idle_strobes"}, strobes(), 0);
        a_in  = v.a;
        b_in  = v.b;
        start = 1'b1;
        @(posedge clk);
        while (done_cyc < 0 && cyc < 200) begin
            @(negedge clk);
            cyc++;
            if (!hold) start = pulse_mid && (cyc == 3);
            c_shla += int'(ShlA);
            c_shlb += int'(ShlB);
            c_shr  += int'(ShrOut);
            c_cu   += int'(cntU);
            c_cd   += int'(cntD);
            c_lo   += int'(loadOut);
            if ((cntU && cntD) || (zero && !done) || ready)
                check({tag, "_cycle_sanity"}, int'({cntU, cntD, zero && !done, ready}), 0);
            if (done) begin
                done_cyc = cyc;
                zero_at  = int'(zero);
            end
        end
        check({tag, "_done_cycle"}, done_cyc, v.done_cyc);
        check({tag, "_shla"}, c_shla, v.shla);
        check({tag, "_shlb"}, c_shlb, v.shlb);
        check({tag, "_shrout"}, c_shr, v.shr);
        check({tag, "_cntu"}, c_cu, v.shla + v.shlb);
        check({tag, "_cntd"}, c_cd, v.shr);
        check({tag, "_loadout"}, c_lo, v.loadout);
        check({tag, "_zero"}, zero_at, v.zero);
    endtask

    vec_t tbl[6];

    initial begin
        tbl[0] = '{16'h8000, 16'h8000,  6,  0,  0,  0, 0, 1};
        tbl[1] = '{16'h0001, 16'h4000, 38, 15,  1, 16, 0, 1};
        tbl[2] = '{16'h0000, 16'h1234, 18, 15,  0,  0, 1, 0};
        tbl[3] = '{16'h00F0, 16'h0F00, 30,  8,  4, 12, 0, 1};
        tbl[4] = '{16'h1234, 16'h0000, 22,  3, 15,  0, 1, 0};
        tbl[5] = '{16'hFFFF, 16'h0001, 36,  0, 15, 15, 0, 1};

        // Reset state.
        repeat (2) @(negedge clk);
        check("reset_ready", int'(ready), 1);
        check("reset_strobes", strobes(), 0);
        rst = 1'b0;
        @(negedge clk);
        check("idle_after_reset", int'(ready), 1);

        for (int i = 0; i < 6; i++) run_op(tbl[i], 1'b0, 1'b0, $sformatf("tbl%0d", i));

        // Start pulsed during SHIFT_A is ignored.
        run_op(expect_vec(16'h0010, 16'h0300), 1'b1, 1'b0, "mid_start");

        // Async reset during SHIFT_OUT, then a normal operation.
        wait_ready("rst_seq");
        a_in  = 16'h00F0;
        b_in  = 16'h0F00;
        start = 1'b1;
        @(posedge clk);
        @(negedge clk);
        start = 1'b0;
        repeat (19) @(negedge clk);
        check("pre_rst_shiftout", int'(ShrOut), 1);
        rst = 1'b1;
        #1;
        check("midrst_ready", int'(ready), 1);
        check("midrst_strobes", strobes(), 0);
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        check("post_rst_idle", int'(ready), 1);
        run_op(tbl[3], 1'b0, 1'b0, "after_rst");

        // Start held high: exactly one IDLE cycle between done and the next LOAD.
        run_op(tbl[0], 1'b0, 1'b1, "held1");
        @(negedge clk);
        check("held_idle_ready", int'(ready), 1);
        check("held_idle_strobes", strobes(), 0);
        @(negedge clk);
        check("held_reload", int'({loadA, loadB, rst5, ready}), 4'b1110);
        start = 1'b0;
        begin
            int n = 0;
            while (!done && n < 100) begin
                @(negedge clk);
                n++;
            end
            check("held2_done_cycle", n + 1, 6);
        end

        // Randomized operands against the reference timing.
        for (int i = 0; i < 25; i++) begin
            logic [15:0] ra, rb;
            ra = 16'($urandom_range(0, 65535) >> $urandom_range(0, 16));
            rb = 16'($urandom_range(0, 65535) >> $urandom_range(0, 16));
            run_op(expect_vec(ra, rb), 1'b0, 1'b0, $sformatf("rnd%0d", i));
        end

        wait_ready("final");
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
